// File: rtl/menu_textbuf_if.sv
// Command and BRAM port-A bundle for the menu text buffer controller.
// master: menu CPU/loader plus the BRAM port A data return; slave: the controller.
interface menu_textbuf_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 7
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_arg;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] cur_addr;
  logic              busy;
  logic              ram_ce;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_ad;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, ram_dout,
    input  cmd_ready, rd_valid, rd_data, cur_addr, busy,
           ram_ce, ram_we, ram_ad, ram_din
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, ram_dout,
    output cmd_ready, rd_valid, rd_data, cur_addr, busy,
           ram_ce, ram_we, ram_ad, ram_din
  );
endinterface

// File: rtl/menu_textbuf_ctrl.sv
// Port-A sequencer for the 1024x7 menu text buffer: cursor writes, screen
// clear/fill and single-character readback. Port B belongs to the OSD scanner.
module menu_textbuf_ctrl #(
  parameter int COLS   = 32,
  parameter int ROWS   = 28,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 7
) (
  input  logic         clk,
  input  logic         resetn,
  menu_textbuf_if.slave bus
);
  localparam int                CB   = $clog2(COLS);
  localparam int                FW   = ADDR_W / 2;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROWS * COLS - 1);
  localparam logic [DATA_W-1:0] NL   = DATA_W'(10);

  localparam logic [1:0] OP_SETPOS = 2'b00;
  localparam logic [1:0] OP_PUTC   = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  typedef enum logic [1:0] {IDLE, CLEAR, RDWAIT} state_t;

  state_t            state_q, state_d;
  logic              rd_phase_q;
  logic [ADDR_W-1:0] cursor_q;
  logic              ce_q, we_q;
  logic [ADDR_W-1:0] ad_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              accept;
  logic [DATA_W-1:0] arg_char;

  logic [ADDR_W-1:0] row_c, col_c, pos_addr, cur_row, nl_addr, inc_addr;

  assign accept   = bus.cmd_valid & bus.cmd_ready;
  assign arg_char = bus.cmd_arg[DATA_W-1:0];

  // Cursor arithmetic: clamped SETPOS target, newline target, and wrapping increment.
  always_comb begin
    row_c = ADDR_W'(bus.cmd_arg[ADDR_W-1:FW]);
    col_c = ADDR_W'(bus.cmd_arg[FW-1:0]);
    if (row_c >= ADDR_W'(ROWS)) row_c = ADDR_W'(ROWS - 1);
    if (col_c >= ADDR_W'(COLS)) col_c = ADDR_W'(COLS - 1);
    pos_addr = (row_c << CB) | col_c;
    cur_row  = cursor_q >> CB;
    nl_addr  = (cur_row == ADDR_W'(ROWS - 1)) ? '0 : ((cur_row + ADDR_W'(1)) << CB);
    inc_addr = (cursor_q == LAST) ? '0 : cursor_q + ADDR_W'(1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state: CLEAR ends on the last cell, RDWAIT spans the BRAM latency plus capture.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && bus.cmd_op == OP_CLEAR)     state_d = CLEAR;
        else if (accept && bus.cmd_op == OP_READ) state_d = RDWAIT;
      end
      CLEAR:   if (ad_q == LAST) state_d = IDLE;
      RDWAIT:  if (rd_phase_q)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Port-A access issue, cursor update and read capture; all outputs are registered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_phase_q <= 1'b0;
      cursor_q   <= '0;
      ce_q       <= 1'b0;
      we_q       <= 1'b0;
      ad_q       <= '0;
      din_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      ce_q       <= 1'b0;
      we_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            unique case (bus.cmd_op)
              OP_SETPOS: cursor_q <= pos_addr;
              OP_PUTC: begin
                if (arg_char == NL) begin
                  cursor_q <= nl_addr;
                end else begin
                  ce_q     <= 1'b1;
                  we_q     <= 1'b1;
                  ad_q     <= cursor_q;
                  din_q    <= arg_char;
                  cursor_q <= inc_addr;
                end
              end
              OP_CLEAR: begin
                ce_q  <= 1'b1;
                we_q  <= 1'b1;
                ad_q  <= '0;
                din_q <= arg_char;
              end
              OP_READ: begin
                ce_q       <= 1'b1;
                ad_q       <= bus.cmd_arg;
                rd_phase_q <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        CLEAR: begin
          if (ad_q == LAST) begin
            cursor_q <= '0;
          end else begin
            ce_q <= 1'b1;
            we_q <= 1'b1;
            ad_q <= ad_q + ADDR_W'(1);
          end
        end
        RDWAIT: begin
          if (rd_phase_q) begin
            rd_data_q  <= bus.ram_dout;
            rd_valid_q <= 1'b1;
            rd_phase_q <= 1'b0;
          end else begin
            rd_phase_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Gating with resetn keeps the RAM from committing anything on the reset edge itself.
  assign bus.ram_ce    = ce_q & resetn;
  assign bus.ram_we    = we_q & ce_q & resetn;
  assign bus.ram_ad    = ad_q;
  assign bus.ram_din   = din_q;
  assign bus.cmd_ready = (state_q == IDLE) & resetn;
  assign bus.busy      = (state_q != IDLE);
  assign bus.cur_addr  = cursor_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
endmodule

// File: tb/tb_menu_textbuf_ctrl.sv
// Bench for menu_textbuf_ctrl: BRAM port-A model, row/col cursor model and screen shadow.
module tb_menu_textbuf_ctrl;
  localparam int COLS  = 32;
  localparam int ROWS  = 28;
  localparam int CELLS = COLS * ROWS;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  menu_textbuf_if bus ();
  menu_textbuf_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus));

  // BRAM port A: synchronous write, registered read (1-cycle latency).
  logic [6:0] mem [1024] = '{default: '0};
  logic [6:0] dout_q = '0;
  int         wcount = 0;
  assign bus.ram_dout = dout_q;
  always @(posedge clk) begin
    if (bus.ram_ce) begin
      if (bus.ram_we) begin
        mem[bus.ram_ad] <= bus.ram_din;
        wcount          <= wcount + 1;
      end else begin
        dout_q <= mem[bus.ram_ad];
      end
    end
  end

  int         checks   = 0;
  int         failures = 0;
  int         cur_row  = 0;
  int         cur_col  = 0;
  logic [6:0] screen [1024] = '{default: '0};

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int maddr();
    return cur_row * COLS + cur_col;
  endfunction

  task automatic adv_char();
    cur_col++;
    if (cur_col == COLS) begin
      cur_col = 0;
      cur_row = (cur_row + 1) % ROWS;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [9:0] arg);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    while (!bus.cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_setpos(input int r, input int c);
    send(2'b00, {5'(r), 5'(c)});
    @(negedge clk);
    chk("setpos_no_access", int'(bus.ram_ce), 0);
    cur_row = (r >= ROWS) ? ROWS - 1 : r;
    cur_col = (c >= COLS) ? COLS - 1 : c;
    chk("setpos_cur", int'(bus.cur_addr), maddr());
  endtask

  task automatic do_putc(input logic [6:0] ch);
    int a;
    a = maddr();
    send(2'b01, {3'b000, ch});
    @(negedge clk);
    if (ch == 7'h0A) begin
      chk("nl_no_write", int'(bus.ram_ce), 0);
      cur_col = 0;
      cur_row = (cur_row + 1) % ROWS;
    end else begin
      chk("putc_ce_we", int'({bus.ram_ce, bus.ram_we}), 3);
      chk("putc_ad", int'(bus.ram_ad), a);
      chk("putc_din", int'(bus.ram_din), int'(ch));
      screen[10'(a)] = ch;
      adv_char();
    end
    chk("putc_cur", int'(bus.cur_addr), maddr());
  endtask

  task automatic do_read(input int a);
    int c0;
    c0 = maddr();
    send(2'b11, 10'(a));
    @(negedge clk);
    chk("rd_issue_ce_we", int'({bus.ram_ce, bus.ram_we}), 2);
    chk("rd_issue_ad", int'(bus.ram_ad), a);
    chk("rd_busy", int'({bus.busy, bus.cmd_ready}), 2);
    chk("rd_valid_early1", int'(bus.rd_valid), 0);
    @(negedge clk);
    chk("rd_valid_early2", int'(bus.rd_valid), 0);
    @(negedge clk);
    chk("rd_valid", int'(bus.rd_valid), 1);
    chk("rd_data", int'(bus.rd_data), int'(screen[10'(a)]));
    chk("rd_cur_unchanged", int'(bus.cur_addr), c0);
    @(negedge clk);
    chk("rd_valid_pulse", int'(bus.rd_valid), 0);
  endtask

  task automatic do_clear(input logic [6:0] f);
    int good;
    int w0;
    good = 0;
    send(2'b10, {3'b000, f});
    w0 = wcount;
    for (int i = 0; i < CELLS; i++) begin
      @(negedge clk);
      if (bus.ram_ce && bus.ram_we && int'(bus.ram_ad) == i && bus.ram_din == f &&
          !bus.cmd_ready && bus.busy) good++;
    end
    chk("clear_seq", good, CELLS);
    @(negedge clk);
    chk("clear_done_ready", int'({bus.cmd_ready, bus.ram_ce}), 2);
    chk("clear_cur", int'(bus.cur_addr), 0);
    chk("clear_wcount", wcount - w0, CELLS);
    for (int a = 0; a < CELLS; a++) screen[10'(a)] = f;
    cur_row = 0;
    cur_col = 0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_ce_we"}, int'({bus.ram_ce, bus.ram_we}), 0);
    chk({pfx, "_ad"}, int'(bus.ram_ad), 0);
    chk({pfx, "_din"}, int'(bus.ram_din), 0);
    chk({pfx, "_rdv"}, int'(bus.rd_valid), 0);
    chk({pfx, "_rdd"}, int'(bus.rd_data), 0);
    chk({pfx, "_cur"}, int'(bus.cur_addr), 0);
    chk({pfx, "_busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] bb [4];
    int         w0, w1, lowc, sel;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_arg   = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    chk("rst_ready_low", int'(bus.cmd_ready), 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_ready", int'(bus.cmd_ready), 1);

    // Directed cursor cases.
    do_setpos(3, 5);
    do_putc(7'h41);
    chk("t1_ad", int'(bus.ram_ad), 'h065);
    chk("t1_cur", int'(bus.cur_addr), 'h066);
    do_setpos(27, 31);
    do_putc(7'h42);
    chk("t2_ad", int'(bus.ram_ad), 'h37F);
    chk("t2_cur", int'(bus.cur_addr), 'h000);
    do_setpos(2, 7);
    do_putc(7'h0A);
    chk("t3_cur", int'(bus.cur_addr), 'h060);
    do_setpos(31, 31);
    chk("clamp_cur", int'(bus.cur_addr), 'h37F);
    do_putc(7'h0A);
    chk("nl_wrap_cur", int'(bus.cur_addr), 0);

    // Back-to-back PUTCs across a row boundary.
    do_setpos(5, 30);
    for (int i = 0; i < 4; i++) bb[i] = 7'($urandom_range(32, 126));
    w0 = wcount;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_arg   = {3'b000, bb[0]};
    for (int i = 0; i < 4; i++) begin
      w1 = maddr();
      @(negedge clk);
      chk("b2b_we", int'({bus.ram_ce, bus.ram_we, bus.cmd_ready}), 7);
      chk("b2b_ad", int'(bus.ram_ad), w1);
      chk("b2b_din", int'(bus.ram_din), int'(bb[i]));
      screen[10'(w1)] = bb[i];
      adv_char();
      if (i < 3) bus.cmd_arg = {3'b000, bb[i+1]};
      else       bus.cmd_valid = 1'b0;
    end
    @(negedge clk);
    chk("b2b_count", wcount - w0, 4);
    chk("b2b_cur", int'(bus.cur_addr), maddr());

    // Full clear then readback of the last cell.
    do_clear(7'h20);
    do_read('h37F);

    // Reset while the 100th clear write is on the port.
    send(2'b10, {3'b000, 7'h11});
    w0 = wcount;
    repeat (100) @(negedge clk);
    chk("rmc_ad", int'(bus.ram_ad), 99);
    w1 = wcount;
    chk("rmc_pre", w1 - w0, 99);
    resetn = 1'b0;
    @(negedge clk);
    chk("rmc_nowrite", wcount - w1, 0);
    chk_reset_outputs("rmc");
    resetn = 1'b1;
    @(negedge clk);
    chk("rmc_ready", int'(bus.cmd_ready), 1);
    chk("rmc_nowrite2", wcount - w1, 0);
    for (int a = 0; a < 99; a++) screen[10'(a)] = 7'h11;
    cur_row = 0;
    cur_col = 0;
    do_read(98);
    do_read(99);

    // PUTC held valid through a CLEAR.
    w0 = wcount;
    send(2'b10, {3'b000, 7'h2E});
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_arg   = {3'b000, 7'h55};
    lowc = 0;
    do begin
      @(negedge clk);
      if (!bus.cmd_ready) lowc++;
    end while (!bus.cmd_ready && lowc < 2000);
    chk("hold_low_cycles", lowc, CELLS);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("hold_we", int'({bus.ram_ce, bus.ram_we}), 3);
    chk("hold_ad", int'(bus.ram_ad), 0);
    chk("hold_din", int'(bus.ram_din), 'h55);
    @(negedge clk);
    chk("hold_count", wcount - w0, CELLS + 1);
    chk("hold_cur", int'(bus.cur_addr), 1);
    for (int a = 0; a < CELLS; a++) screen[10'(a)] = 7'h2E;
    screen[0] = 7'h55;
    cur_row = 0;
    cur_col = 1;

    // Randomized command mix against the row/col and screen model.
    for (int k = 0; k < 250; k++) begin
      sel = $urandom_range(0, 99);
      if (sel < 20)      do_setpos($urandom_range(0, 31), $urandom_range(0, 31));
      else if (sel < 65) do_putc(($urandom_range(0, 9) == 0) ? 7'h0A : 7'($urandom_range(0, 127)));
      else if (sel < 98) do_read($urandom_range(0, 1023));
      else               do_clear(7'($urandom_range(0, 127)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
